arbiter_requester: RTL and testbench
====================================

Name: arbiter_requester

Overview:
- Client-side request agent for the 3-way shared-resource arbiter; one instance per requester (ID 0, 1 or 2).
- Accepts burst jobs from local logic and drives the requester's request line (X0/X1/X2) into the arbiter.
- Watches the arbiter's 2-bit grant state (Q1:Q0) and asserts bus ownership for the job's beat count.
- Releases the request afterwards and enforces an idle gap before the next job, so the arbiter can rotate grants.

Parameters:
- ID, 0, requester index 0..2; grant code matching this requester = ID+1 (2'b01, 2'b10, 2'b11); 2'b00 = no grant.
- LEN_W, 4, width of job_len.
- GAP, 1, minimum idle cycles after release before job_ready reasserts (0..15).
- TIMEOUT, 64, max cycles waiting for grant; used only with the optional feature.

Ports:
- CLK  input  1  clock, rising edge.
- RST  input  1  synchronous reset, active-high.
- job_valid  input  1  local job request.
- job_len  input  LEN_W  beats to transfer; 0 = null job.
- job_ready  output  1  agent can accept a job.
- req  output  1  request line to arbiter (this requester's X input).
- gnt_code  input  2  arbiter grant state {Q1,Q0}.
- own  output  1  resource owned this cycle; one beat per cycle while high.
- done  output  1  one-cycle pulse when a job completes.
- busy  output  1  high from job accept until return to IDLE.
- timeout  output  1  one-cycle pulse on grant-wait abort; tied 0 when the feature is compiled out.

Behaviour:
- All outputs are registered (Moore).
- Reset values: job_ready=0, req=0, own=0, done=0, busy=0, timeout=0, state=IDLE, counters=0. job_ready rises on the first cycle after RST deasserts.
- States: IDLE, REQ, OWN, REL.
- IDLE:
  - job_ready=1.
  - Accept when job_valid & job_ready; latch job_len into rem.
  - len=0: go to REL; done pulses on the next cycle; req is never raised.
  - len>0: go to REQ; req=1 on the cycle after accept.
- REQ:
  - req=1, own=0.
  - If sampled gnt_code == ID+1: go to OWN; own=1 on the next cycle.
- OWN:
  - req=1, own=1; rem decrements each cycle own=1.
  - Last beat when rem==1: next state REL.
  - If gnt_code != ID+1 while in OWN (preemption): go to REQ; own=0 next cycle; rem is kept and the remaining beats finish on re-grant.
- REL:
  - req=0, own=0, busy=1. done=1 on the first REL cycle only.
  - Hold GAP cycles counted from the first REL cycle, then go to IDLE; busy=0 and job_ready=1 at that point.
  - GAP=0: REL lasts exactly 1 cycle.
- Beat count:
  - Exactly len own-cycles per job, including across preemptions.
  - rem width = LEN_W; no wrap. Max job = 2^LEN_W-1 beats.
- job_valid outside IDLE is ignored; no queueing.
- gnt_code values naming other requesters, or 2'b00, are treated as "not granted".
- Reset mid-operation returns to IDLE the next cycle with all outputs at reset values. The job is dropped and done never fires.

Optional Feature:
- Macro ARB_REQ_TIMEOUT_EN.
- Defined:
  - Wait counter clears on entering REQ and counts REQ cycles; it is not cleared by a preemption return.
  - At TIMEOUT consecutive REQ cycles without grant: req drops, timeout pulses 1 cycle, state goes to REL. done does not pulse; the GAP hold still applies.
- Undefined: the agent waits for grant indefinitely; timeout is constant 0 and no wait counter exists.

Test Plan:
- ID=1, GAP=1: job_len=3 accepted at cycle 0, gnt_code=2'b10 from cycle 2 → req=1 from cycle 1; own=1 cycles 3-5; done pulse cycle 6; job_ready=1 cycle 7.
- ID=0: job_len=0 → req stays 0, done pulses 1 cycle after accept, job_ready returns after GAP.
- ID=2, job_len=5: grant for 2 beats, then gnt_code=2'b01 for 3 cycles, then 2'b11 again → own total 5 cycles, req held high throughout, single done pulse.
- RST asserted in OWN with rem=4 → next cycle req=0, own=0, busy=0, no done; job_ready=1 the cycle after RST falls.
- With ARB_REQ_TIMEOUT_EN, TIMEOUT=8, gnt_code held 2'b00 → timeout pulse after 8 REQ cycles, req=0, done never asserted. Without the macro: req stays high for 100+ cycles and timeout=0.
- job_valid held high with job_len=2 back-to-back, continuous grant → each job gives 2 own cycles, ≥GAP+1 cycles with req=0 between jobs.

Source files
------------

// File: rtl/arbiter_requester.sv
// arbiter_requester: client agent for a 3-way arbiter; takes a burst job (job_valid/job_len/job_ready), raises req, owns the resource (own) while gnt_code==ID+1 for job_len beats, then pulses done and holds busy through a GAP idle; optional grant-wait abort (timeout) under ARB_REQ_TIMEOUT_EN
module arbiter_requester #(
  parameter int ID = 0,
  parameter int LEN_W = 4,
  parameter int GAP = 1,
  parameter int TIMEOUT = 64
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             job_valid,
  input  logic [LEN_W-1:0] job_len,
  output logic             job_ready,
  output logic             req,
  input  logic [1:0]       gnt_code,
  output logic             own,
  output logic             done,
  output logic             busy,
  output logic             timeout
);
  localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, OWN = 2'd2, REL = 2'd3;
  localparam logic [1:0] MY = 2'(ID + 1);
  localparam logic [3:0] HOLD = GAP == 0 ? 4'd1 : 4'(GAP);
  if (ID < 0 || ID > 2 || GAP < 0 || GAP > 15 || TIMEOUT < 1) begin : g_bad_param
    $error("arbiter_requester: parameter out of range");
  end
  logic [1:0] state, state_n;
  logic [LEN_W-1:0] rem, rem_n;
  logic [3:0] gcnt, gcnt_n;
  logic granted, to_n;
  assign granted = gnt_code == MY;
`ifdef ARB_REQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wcnt, wcnt_n;
`endif
  always_comb begin
    state_n = state;
    rem_n = rem;
    gcnt_n = state == REL ? gcnt + 4'd1 : 4'd1;
    to_n = 1'b0;
`ifdef ARB_REQ_TIMEOUT_EN
    wcnt_n = state == IDLE ? '0 : state == REQ ? wcnt + 1'b1 : wcnt;
    to_n = state == REQ && !granted && wcnt == TW'(TIMEOUT - 1);
`endif
    case (state)
      IDLE: if (job_valid && job_ready) begin
        rem_n = job_len;
        state_n = job_len == '0 ? REL : REQ;
      end
      REQ: state_n = granted ? OWN : to_n ? REL : REQ;
      OWN: begin
        rem_n = rem - 1'b1;
        state_n = rem == LEN_W'(1) ? REL : granted ? OWN : REQ;
      end
      default: state_n = gcnt >= HOLD ? IDLE : REL;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      rem <= '0;
      gcnt <= '0;
      job_ready <= 1'b0;
      req <= 1'b0;
      own <= 1'b0;
      done <= 1'b0;
      busy <= 1'b0;
      timeout <= 1'b0;
`ifdef ARB_REQ_TIMEOUT_EN
      wcnt <= '0;
`endif
    end else begin
      state <= state_n;
      rem <= rem_n;
      gcnt <= gcnt_n;
      job_ready <= state_n == IDLE;
      req <= state_n == REQ || state_n == OWN;
      own <= state_n == OWN;
      done <= state_n == REL && state != REL && !to_n;
      busy <= state_n != IDLE;
      timeout <= to_n;
`ifdef ARB_REQ_TIMEOUT_EN
      wcnt <= wcnt_n;
`endif
    end
  end
endmodule

// File: tb/tb_arbiter_requester.sv
// tb_arbiter_requester: directed plus random stimulus for arbiter_requester, checked every cycle against a job-level reference model
module tb_arbiter_requester;
  localparam int ID = 1, LEN_W = 4, GAP = 2, TIMEOUT = 8;
  localparam logic [1:0] MY = 2'(ID + 1);
  localparam int HOLD = GAP > 1 ? GAP : 1;
  logic CLK = 1'b0, RST = 1'b1, job_valid = 1'b0;
  logic [LEN_W-1:0] job_len = '0;
  logic [1:0] gnt_code = 2'b00;
  logic job_ready, req, own, done, busy, timeout;
  int checks = 0, errors = 0;
  logic m_ready = 0, m_req = 0, m_own = 0, m_done = 0, m_busy = 0, m_to = 0;
  int left = 0, relc = 0, waited = 0;
  arbiter_requester #(.ID(ID), .LEN_W(LEN_W), .GAP(GAP), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RST(RST), .job_valid(job_valid), .job_len(job_len), .job_ready(job_ready),
    .req(req), .gnt_code(gnt_code), .own(own), .done(done), .busy(busy), .timeout(timeout)
  );
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
    end
  endtask
  task automatic model_step();
    if (RST) begin
      {m_ready, m_req, m_own, m_done, m_busy, m_to} = '0;
      left = 0;
      relc = 0;
      waited = 0;
    end else begin
      m_done = 0;
      m_to = 0;
      if (m_ready && job_valid) begin
        m_ready = 0;
        m_busy = 1;
        left = int'(job_len);
        waited = 0;
        if (left == 0) begin
          relc = 1;
          m_done = 1;
        end else m_req = 1;
      end else if (relc > 0) begin
        if (relc >= HOLD) begin
          relc = 0;
          m_busy = 0;
          m_ready = 1;
        end else relc++;
      end else if (m_own) begin
        left--;
        if (left == 0) begin
          m_own = 0;
          m_req = 0;
          relc = 1;
          m_done = 1;
        end else m_own = gnt_code == MY;
      end else if (m_req) begin
        waited++;
        if (gnt_code == MY) m_own = 1;
`ifdef ARB_REQ_TIMEOUT_EN
        else if (waited == TIMEOUT) begin
          m_req = 0;
          m_to = 1;
          relc = 1;
        end
`endif
      end else m_ready = 1;
    end
  endtask
  task automatic cyc();
    @(posedge CLK);
    model_step();
    #1;
    chk("job_ready", job_ready, m_ready);
    chk("req", req, m_req);
    chk("own", own, m_own);
    chk("done", done, m_done);
    chk("busy", busy, m_busy);
    chk("timeout", timeout, m_to);
  endtask
  task automatic job(input int len);
    job_valid = 1'b1;
    job_len = LEN_W'(len);
    cyc();
    job_valid = 1'b0;
  endtask
  initial begin
    repeat (2) cyc();
    RST = 1'b0;
    cyc();
    job(3);
    cyc();
    gnt_code = MY;
    repeat (8) cyc();
    gnt_code = 2'b00;
    job(0);
    repeat (5) cyc();
    gnt_code = MY;
    job(5);
    repeat (3) cyc();
    gnt_code = 2'b01;
    repeat (3) cyc();
    gnt_code = MY;
    repeat (8) cyc();
    job(8);
    for (int i = 0; i < 20 && !(m_own && left == 4); i++) cyc();
    checks++;
    assert (m_own && left == 4) else begin
      errors++;
      $error("FAIL reach_own_rem4 observed=%0d expected=4", left);
    end
    RST = 1'b1;
    cyc();
    RST = 1'b0;
    repeat (3) cyc();
    gnt_code = 2'b00;
    job(4);
    for (int i = 0; i < 110; i++) begin
      gnt_code = 2'((int'(MY) + 1 + int'($urandom_range(0, 2))) % 4);
      cyc();
    end
    gnt_code = MY;
    repeat (12) cyc();
    job_valid = 1'b1;
    job_len = LEN_W'(2);
    repeat (30) cyc();
    job_valid = 1'b0;
    repeat (1500) begin
      RST = $urandom_range(0, 149) == 0;
      job_valid = 1'($urandom);
      job_len = $urandom_range(0, 3) == 0 ? '0 : LEN_W'($urandom_range(1, 15));
      gnt_code = $urandom_range(0, 2) != 0 ? MY : 2'($urandom);
      cyc();
    end
    RST = 1'b0;
    repeat (3) cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
